// File: rtl/rll_pkg.sv
// -----------------------------------------------------------------------------
// rll_pkg
//   Shared types and sizing helpers for the RLL sequential key-gate unit.
//   - key_state_e : key loader FSM states
//   - num_beats   : number of load beats needed to fill a KEY_W-bit key
//   - beat_cnt_w  : width of the beat counter for a given key/beat geometry
// -----------------------------------------------------------------------------
package rll_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2,
    ERROR = 2'd3
  } key_state_e;

  function automatic int num_beats(input int key_w, input int load_w);
    return key_w / load_w;
  endfunction

  // One spare bit so the counter never wraps at the final beat index.
  function automatic int beat_cnt_w(input int key_w, input int load_w);
    return $clog2(num_beats(key_w, load_w)) + 1;
  endfunction

  // Counter width for the default 32-bit key loaded one bit per beat.
  localparam int BEAT_CNT_W = $clog2(num_beats(32, 1)) + 1;

endpackage

// File: rtl/rll_key_loader.sv
// -----------------------------------------------------------------------------
// rll_key_loader
//   Serial key loader: FSM, beat counter, key write register and optional
//   parity check. Beats arrive LSB first, LOAD_W bits at a time.
//   Optional feature: define KEY_PARITY_EN to require even parity over the
//   assembled key (including key_par) before arming.
// Ports
//   clk, rst_n            clock, async active-low reset
//   key_valid/key_ready   load beat handshake
//   key_data              beat payload (LOAD_W)
//   key_last              final-beat marker
//   key_par               even-parity bit, sampled with the final beat
//   key_clear             synchronous wipe back to IDLE (highest priority)
//   key                   assembled key (zero unless loaded/armed)
//   key_armed, key_err    registered status flags
// -----------------------------------------------------------------------------
module rll_key_loader
  import rll_pkg::*;
#(
  parameter int KEY_W  = 32,
  parameter int LOAD_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [LOAD_W-1:0] key_data,
  input  logic              key_last,
  input  logic              key_par,
  input  logic              key_clear,
  output logic [KEY_W-1:0]  key,
  output logic              key_armed,
  output logic              key_err
);

  localparam int NB    = num_beats(KEY_W, LOAD_W);
  localparam int CNT_W = beat_cnt_w(KEY_W, LOAD_W);

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             accept;
  logic             final_beat;
  logic             par_ok;

  // rst_n is folded in so the port reads 0 for as long as reset is held,
  // not just after the first clock edge.
  assign key_ready  = rst_n & ((state_q == IDLE) | (state_q == LOAD));
  assign accept     = key_valid & key_ready;
  assign final_beat = (cnt_q == CNT_W'(NB - 1));

`ifdef KEY_PARITY_EN
  assign par_ok = ~((^key_d) ^ key_par);
`else
  logic unused_par;
  assign unused_par = key_par;
  assign par_ok     = 1'b1;
`endif

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;

    if (key_clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      key_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, LOAD: begin
          if (accept) begin
            for (int b = 0; b < NB; b++) begin
              if (cnt_q == CNT_W'(b)) key_d[b*LOAD_W +: LOAD_W] = key_data;
            end
            if (final_beat) begin
              if (key_last && par_ok) begin
                state_d = ARMED;
              end else begin
                state_d = ERROR;
                key_d   = '0;
              end
            end else if (key_last) begin
              state_d = ERROR;
              key_d   = '0;
            end else begin
              state_d = LOAD;
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end
        end
        ARMED: ;
        ERROR: key_d = '0;
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          key_d   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
    end
  end

  assign key       = key_q;
  assign key_armed = (state_q == ARMED);
  assign key_err   = (state_q == ERROR);

endmodule

// File: rtl/rll_seq_key_unit.sv
// -----------------------------------------------------------------------------
// rll_seq_key_unit
//   Sequential key-gate array for RLL-locked netlists. A serially loaded key
//   drives DATA_W XOR/XNOR key gates; lanes at or above KEY_W pass through.
//   Output is registered (1-cycle latency). Until the key is armed the gates
//   see key=0, so XNOR lanes stay inverted (locked behaviour).
//   Optional feature: KEY_PARITY_EN (see rll_key_loader).
// Ports
//   clk, rst_n                 clock, async active-low reset
//   key_valid/ready/data/last  serial key load port
//   key_par, key_clear         parity bit, synchronous key wipe
//   in_valid, in_data          unlocked-side nets (no backpressure)
//   out_valid, out_data        registered key-gated nets
//   key_armed, key_err         loader status
// -----------------------------------------------------------------------------
module rll_seq_key_unit
  import rll_pkg::*;
#(
  parameter int               DATA_W   = 32,
  parameter int               KEY_W    = 32,
  parameter int               LOAD_W   = 1,
  parameter logic [KEY_W-1:0] POLARITY = 32'h2C6A_44E4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [LOAD_W-1:0] key_data,
  input  logic              key_last,
  input  logic              key_par,
  input  logic              key_clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              key_armed,
  output logic              key_err
);

  logic [KEY_W-1:0]  key;
  logic [KEY_W-1:0]  eff;
  logic [DATA_W-1:0] mask;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  rll_key_loader #(
    .KEY_W  (KEY_W),
    .LOAD_W (LOAD_W)
  ) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_data  (key_data),
    .key_last  (key_last),
    .key_par   (key_par),
    .key_clear (key_clear),
    .key       (key),
    .key_armed (key_armed),
    .key_err   (key_err)
  );

  // key_armed is registered, so a data beat sampled on the arming edge still
  // sees the pre-arm mask.
  assign eff = (key & {KEY_W{key_armed}}) ^ POLARITY;

  always_comb begin
    mask            = '0;
    mask[KEY_W-1:0] = eff;
    out_valid_d     = in_valid;
    out_data_d      = in_valid ? (in_data ^ mask) : out_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
